// File: rtl/whack_pkg.sv
// Shared constants for the whack game datapath: score width/ceiling,
// high_score_tracker state encodings and a counter-width helper.
package whack_pkg;

    localparam int SCORE_WIDTH = 14;      // $clog2(9999)
    localparam int MAX_SCORE   = 9999;

    // high_score_tracker FSM encodings (also exported on state_debug)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PLAYING = 3'd1;
    localparam logic [2:0] ST_COMPARE = 3'd2;
    localparam logic [2:0] ST_FLASH   = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    // Width of a counter that must hold 0..n-1, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond tick: counts 0..CLKS_PER_MS-1 and asserts tick
// for the single cycle in which the count sits at its last value, so the
// consumer acts on the wrap edge. clear restarts the count from 0.
module ms_tick_gen
    import whack_pkg::*;
#(
    parameter int CLKS_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int              CW   = cnt_w(CLKS_PER_MS);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_MS - 1);

    logic [CW-1:0] cnt;

    // Cycle counter, wraps at LAST, restarted by reset or clear
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/high_score_tracker.sv
// Tracks the best game score and drives the four-digit display: live score
// while playing, a flashing final score after a new record, and the held
// final score / best score between games. All outputs are registered.
module high_score_tracker #(
    parameter int SCORE_WIDTH     = whack_pkg::SCORE_WIDTH,
    parameter int MAX_SCORE       = whack_pkg::MAX_SCORE,
    parameter int CLKS_PER_MS     = 50000,
    parameter int FLASH_PERIOD_MS = 250,
    parameter int FLASH_TOGGLES   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   game_in_progress,
    input  logic [SCORE_WIDTH-1:0] score,
    input  logic                   clear_best,
    output logic [SCORE_WIDTH-1:0] display_value,
    output logic                   display_blank,
    output logic [SCORE_WIDTH-1:0] best_score,
    output logic                   new_record,
    output logic [2:0]             state_debug
);

    import whack_pkg::*;

    localparam int PW = cnt_w(FLASH_PERIOD_MS);
    localparam int TW = cnt_w(FLASH_TOGGLES);

    localparam logic [SCORE_WIDTH-1:0] MAX_S  = SCORE_WIDTH'(MAX_SCORE);
    localparam logic [PW-1:0]          P_LAST = PW'(FLASH_PERIOD_MS - 1);
    localparam logic [TW-1:0]          T_LAST = TW'(FLASH_TOGGLES - 1);

    logic [2:0]             state;
    logic                   gip_q;
    logic [SCORE_WIDTH-1:0] cap_q;
    logic [PW-1:0]          ms_cnt;
    logic [TW-1:0]          tog_cnt;
    logic                   ms_tick;
    logic                   rise;
    logic                   fall;
    logic [SCORE_WIDTH-1:0] cap;

    assign rise = game_in_progress & ~gip_q;
    assign fall = ~game_in_progress & gip_q;
    assign cap  = (score > MAX_S) ? MAX_S : score;

    assign state_debug = state;

    // Restart the ms timebase while in COMPARE so the first FLASH toggle
    // lands exactly one flash period after entering FLASH.
    ms_tick_gen #(
        .CLKS_PER_MS (CLKS_PER_MS)
    ) u_ms_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_COMPARE),
        .tick  (ms_tick)
    );

    // Game-state FSM with registered display, best score and record flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            gip_q         <= 1'b0;
            cap_q         <= '0;
            ms_cnt        <= '0;
            tog_cnt       <= '0;
            best_score    <= '0;
            display_value <= '0;
            display_blank <= 1'b0;
            new_record    <= 1'b0;
        end else begin
            gip_q <= game_in_progress;
            case (state)
                ST_IDLE, ST_HOLD: begin
                    display_value <= (state == ST_IDLE) ? best_score : cap_q;
                    display_blank <= 1'b0;
                    // a game start outranks a clear request
                    if (rise) begin
                        state      <= ST_PLAYING;
                        new_record <= 1'b0;
                    end else if (clear_best) begin
                        best_score <= '0;
                        new_record <= 1'b0;
                    end
                end
                ST_PLAYING: begin
                    display_value <= score;
                    display_blank <= 1'b0;
                    if (fall) begin
                        cap_q <= cap;
                        state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    display_value <= cap_q;
                    display_blank <= 1'b0;
                    ms_cnt        <= '0;
                    tog_cnt       <= '0;
                    // only a strict improvement is a record; ties go to HOLD
                    if (cap_q > best_score) begin
                        best_score <= cap_q;
                        new_record <= 1'b1;
                        state      <= ST_FLASH;
                    end else begin
                        state <= ST_HOLD;
                    end
                end
                ST_FLASH: begin
                    display_value <= cap_q;
                    if (rise) begin
                        // best_score is already committed; just abort the flash
                        state         <= ST_PLAYING;
                        display_blank <= 1'b0;
                        new_record    <= 1'b0;
                    end else if (ms_tick) begin
                        if (ms_cnt == P_LAST) begin
                            ms_cnt  <= '0;
                            tog_cnt <= tog_cnt + 1'b1;
                            if (tog_cnt == T_LAST) begin
                                display_blank <= 1'b0;
                                state         <= ST_HOLD;
                            end else begin
                                display_blank <= ~display_blank;
                            end
                        end else begin
                            ms_cnt <= ms_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    display_blank <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/high_score_tracker.md
Name: high_score_tracker

Overview:
- Sits downstream of the score counter and the game FSM.
- Consumes the live score and game_in_progress, and captures the final score when a game ends.
- Compares the final score against a stored best score and updates it on a strict improvement.
- Drives a value and blank flag toward the four-digit score display: a live score during play, a flashing final score on a new record, and the best score when idle.

Parameters:
- SCORE_WIDTH, 14, width of score, best_score and display_value. Equals $clog2(9999).
- MAX_SCORE, 9999, saturation ceiling applied to the captured score.
- CLKS_PER_MS, 50000, clock cycles per millisecond tick.
- FLASH_PERIOD_MS, 250, milliseconds between display_blank toggles in FLASH.
- FLASH_TOGGLES, 8, number of display_blank toggles before leaving FLASH.

Ports:
- clk, in, 1, system clock (CLOCK_50).
- rst, in, 1, synchronous active-low reset. The top level drives it with ~reset_button_pressed.
- game_in_progress, in, 1, high while a game runs (from the FSM).
- score, in, SCORE_WIDTH, live score from the score counter.
- clear_best, in, 1, single-cycle debounced pulse that zeroes the best score.
- display_value, out, SCORE_WIDTH, value for the score display.
- display_blank, out, 1, 1 means the display shows blank digits.
- best_score, out, SCORE_WIDTH, stored best score.
- new_record, out, 1, high from a record-setting game end until the next game start or reset.
- state_debug, out, 3, current FSM state encoding.

Behaviour:
- Reset (rst==0 on a clk edge):
  - state goes to IDLE.
  - best_score, display_value, captured score and all counters go to 0.
  - display_blank and new_record go to 0.
  - Reset overrides every other input on the same cycle.
- Edge detection: game_in_progress is registered once (gip_q).
  - rise = gip & ~gip_q.
  - fall = ~gip & gip_q.
- Capture: cap = (score > MAX_SCORE) ? MAX_SCORE : score. The value is registered on the fall cycle.
- States and transitions:
  - IDLE: display_value=best_score, blank=0. On rise, go to PLAYING and clear new_record.
  - PLAYING: display_value=score, registered with 1-cycle latency. On fall, latch cap and go to COMPARE.
  - COMPARE (1 cycle):
    - If cap > best_score: best_score<=cap, new_record<=1, reset the flash counters, go to FLASH.
    - Otherwise (ties included), go to HOLD.
  - FLASH: display_value=cap.
    - display_blank toggles on every FLASH_PERIOD_MS-th ms tick.
    - After FLASH_TOGGLES toggles, force blank=0 and go to HOLD.
    - A rise aborts the flash: go to PLAYING, blank=0, new_record cleared. best_score is already committed.
  - HOLD: display_value=cap, blank=0. On rise, go to PLAYING and clear new_record.
- Ms tick: a free-running counter from 0 to CLKS_PER_MS-1 produces a 1-cycle tick at wrap. It is cleared on entry to FLASH, so the first toggle lands exactly FLASH_PERIOD_MS after entry.
- clear_best:
  - Honoured only in IDLE and HOLD: best_score<=0 next cycle and new_record<=0.
  - Ignored in PLAYING, COMPARE and FLASH.
- Simultaneous events:
  - rise and fall on the same cycle cannot occur.
  - A rise takes priority over clear_best.
  - A fall while in IDLE or HOLD is impossible by construction. If gip_q is stale after reset, no fall is generated because gip_q resets to 0.
- A game shorter than 2 cycles (rise, then fall next cycle) still passes through PLAYING and COMPARE with correct capture.
- All outputs are registered. No combinational path runs from inputs to outputs.

Decomposition:
- Shared package whack_pkg holds:
  - the state enum (IDLE=0, PLAYING=1, COMPARE=2, FLASH=3, HOLD=4);
  - MAX_SCORE and SCORE_WIDTH constants, shared with score_counter and display_four_digits.
- One sub-module, ms_tick_gen (parameter CLKS_PER_MS; ports clk, rst, clear, tick). The timer module is expected to reuse it.

Test Plan:
- Reset, then hold rst high idle for 10 cycles -> best_score=0, display_value=0, display_blank=0, new_record=0, state_debug=IDLE.
- Game with score=120 at the fall -> best_score=120 two cycles after the fall, new_record=1, state FLASH, blank toggles 8 times at 250 ms spacing, then HOLD with display_value=120.
- Second game ends with score=120 (tie), then another ends with score=80 -> best_score stays 120, new_record=0, no FLASH, HOLD shows 120 then 80.
- Score input 12000 at the fall -> captured and best_score = 9999.
- In FLASH, raise game_in_progress after 3 toggles -> PLAYING next cycle, blank=0, new_record=0, best_score retains the new value. clear_best during PLAYING -> no effect. clear_best in HOLD -> best_score=0.
- Assert rst (low) mid-FLASH and mid-PLAYING -> all outputs 0 and IDLE on the next edge. Releasing rst while game_in_progress=1 -> rise detected, goes to PLAYING.
